// File: rtl/game_flow_ctrl.sv
// Song-lifecycle sequencer: drives chart ROM address, queue shift/blank/clear and judge enable from beat_tick.
// Latency: every output is registered, one cycle after the qualifying input. Backpressure: none; every beat_tick is acted on.
// Optional pause state and its save register are built only when GAME_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int COUNTDOWN_BEATS = 4,
    parameter int DRAIN_BEATS     = 16,
    parameter int ADDR_W          = 12,
    parameter int CHART_LEN       = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_tick,
    input  logic              start_pulse,
    input  logic              pause_pulse,
    output logic [ADDR_W-1:0] chart_addr,
    output logic              shift_pulse,
    output logic              feed_blank,
    output logic              clear_pulse,
    output logic              judge_en,
    output logic [3:0]        countdown,
    output logic [2:0]        state,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_DRAIN     = 3'd3,
        S_PAUSE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CHART_LEN - 1);
    localparam logic [3:0]        CD_INIT    = 4'(COUNTDOWN_BEATS);
    localparam logic [7:0]        DRAIN_INIT = 8'(DRAIN_BEATS);

    state_t     cur;
    logic [7:0] drain_cnt;
    logic       pause_ev;

`ifdef GAME_PAUSE_EN
    // Remembers whether PAUSE was entered from DRAIN (1) or PLAY (0).
    logic       ret_drain;
    assign pause_ev = pause_pulse;
`else
    logic       unused_pause;
    assign unused_pause = pause_pulse;
    assign pause_ev     = 1'b0;
`endif

    assign state = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= S_IDLE;
            chart_addr  <= '0;
            countdown   <= '0;
            drain_cnt   <= '0;
            shift_pulse <= 1'b0;
            clear_pulse <= 1'b0;
            judge_en    <= 1'b0;
            feed_blank  <= 1'b1;
            done        <= 1'b0;
`ifdef GAME_PAUSE_EN
            ret_drain   <= 1'b0;
`endif
        end else begin
            shift_pulse <= 1'b0;
            clear_pulse <= 1'b0;
            if (start_pulse) begin
                // Restart wins over everything; same-cycle tick/pause are dropped.
                cur         <= S_COUNTDOWN;
                countdown   <= CD_INIT;
                chart_addr  <= '0;
                drain_cnt   <= '0;
                clear_pulse <= 1'b1;
                judge_en    <= 1'b0;
                feed_blank  <= 1'b1;
                done        <= 1'b0;
            end else begin
                case (cur)
                    S_IDLE: begin
                    end
                    S_COUNTDOWN: begin
                        if (beat_tick) begin
                            if (countdown <= 4'd1) begin
                                cur        <= S_PLAY;
                                countdown  <= '0;
                                judge_en   <= 1'b1;
                                feed_blank <= 1'b0;
                            end else begin
                                countdown <= countdown - 4'd1;
                            end
                        end
                    end
                    S_PLAY: begin
                        if (pause_ev) begin
                            cur      <= S_PAUSE;
                            judge_en <= 1'b0;
`ifdef GAME_PAUSE_EN
                            ret_drain <= 1'b0;
`endif
                        end else if (beat_tick) begin
                            shift_pulse <= 1'b1;
                            // Address saturates at the last entry; the queue then fills with blanks.
                            if (chart_addr == LAST_ADDR) begin
                                cur        <= S_DRAIN;
                                drain_cnt  <= DRAIN_INIT;
                                feed_blank <= 1'b1;
                            end else begin
                                chart_addr <= chart_addr + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (pause_ev) begin
                            cur      <= S_PAUSE;
                            judge_en <= 1'b0;
`ifdef GAME_PAUSE_EN
                            ret_drain <= 1'b1;
`endif
                        end else if (beat_tick) begin
                            shift_pulse <= 1'b1;
                            if (drain_cnt <= 8'd1) begin
                                cur       <= S_DONE;
                                drain_cnt <= '0;
                                judge_en  <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                drain_cnt <= drain_cnt - 8'd1;
                            end
                        end
                    end
`ifdef GAME_PAUSE_EN
                    S_PAUSE: begin
                        // Counters and feed_blank are untouched while paused.
                        if (pause_ev) begin
                            cur      <= ret_drain ? S_DRAIN : S_PLAY;
                            judge_en <= 1'b1;
                        end
                    end
`endif
                    S_DONE: begin
                    end
                    default: begin
                        cur         <= S_IDLE;
                        chart_addr  <= '0;
                        countdown   <= '0;
                        drain_cnt   <= '0;
                        judge_en    <= 1'b0;
                        feed_blank  <= 1'b1;
                        done        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table for lifecycle steps plus hand sequences for play-through, pause and reset.
module tb_game_flow_ctrl;

    localparam int ADDR_W = 6;
    localparam int CHART_LEN = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              beat_tick = 1'b0;
    logic              start_pulse = 1'b0;
    logic              pause_pulse = 1'b0;
    logic [ADDR_W-1:0] chart_addr;
    logic              shift_pulse;
    logic              feed_blank;
    logic              clear_pulse;
    logic              judge_en;
    logic [3:0]        countdown;
    logic [2:0]        state;
    logic              done;

    int checks = 0;
    int failures = 0;
    int shifts;

    game_flow_ctrl #(
        .COUNTDOWN_BEATS(4),
        .DRAIN_BEATS(3),
        .ADDR_W(ADDR_W),
        .CHART_LEN(CHART_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .beat_tick(beat_tick),
        .start_pulse(start_pulse),
        .pause_pulse(pause_pulse),
        .chart_addr(chart_addr),
        .shift_pulse(shift_pulse),
        .feed_blank(feed_blank),
        .clear_pulse(clear_pulse),
        .judge_en(judge_en),
        .countdown(countdown),
        .state(state),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s, p, t;
        logic [2:0] st;
        logic [5:0] addr;
        logic       sh, clr, je, fb;
        logic [3:0] cd;
        logic       dn;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic t);
        @(negedge clk);
        start_pulse = s;
        pause_pulse = p;
        beat_tick   = t;
        @(posedge clk);
        #1;
        start_pulse = 1'b0;
        pause_pulse = 1'b0;
        beat_tick   = 1'b0;
        if (shift_pulse) shifts++;
    endtask

    initial begin
        //          s  p  t  st addr sh clr je fb cd dn
        vecs[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0};
        vecs[2]  = '{1, 0, 0, 1, 0,  0, 1, 0, 1, 4, 0};
        vecs[3]  = '{0, 0, 0, 1, 0,  0, 0, 0, 1, 4, 0};
        vecs[4]  = '{0, 0, 1, 1, 0,  0, 0, 0, 1, 3, 0};
        vecs[5]  = '{0, 1, 0, 1, 0,  0, 0, 0, 1, 3, 0};
        vecs[6]  = '{0, 0, 1, 1, 0,  0, 0, 0, 1, 2, 0};
        vecs[7]  = '{0, 0, 1, 1, 0,  0, 0, 0, 1, 1, 0};
        vecs[8]  = '{0, 0, 1, 2, 0,  0, 0, 1, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 2, 1,  1, 0, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 2, 2,  1, 0, 1, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 2, 2,  0, 0, 1, 0, 0, 0};
        vecs[12] = '{1, 0, 1, 1, 0,  0, 1, 0, 1, 4, 0};
        vecs[13] = '{0, 0, 1, 1, 0,  0, 0, 0, 1, 3, 0};
        vecs[14] = '{0, 0, 1, 1, 0,  0, 0, 0, 1, 2, 0};
        vecs[15] = '{0, 0, 1, 1, 0,  0, 0, 0, 1, 1, 0};
        vecs[16] = '{0, 0, 1, 2, 0,  0, 0, 1, 0, 0, 0};

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check("rst.state", state, 0);
        check("rst.addr", chart_addr, 0);
        check("rst.feed_blank", feed_blank, 1);
        check("rst.judge_en", judge_en, 0);
        check("rst.strobes", {shift_pulse, clear_pulse, done}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].s, vecs[i].p, vecs[i].t);
            check($sformatf("vec%0d.state", i), state, vecs[i].st);
            check($sformatf("vec%0d.addr", i), chart_addr, vecs[i].addr);
            check($sformatf("vec%0d.shift", i), shift_pulse, vecs[i].sh);
            check($sformatf("vec%0d.clear", i), clear_pulse, vecs[i].clr);
            check($sformatf("vec%0d.judge", i), judge_en, vecs[i].je);
            check($sformatf("vec%0d.blank", i), feed_blank, vecs[i].fb);
            check($sformatf("vec%0d.countdown", i), countdown, vecs[i].cd);
            check($sformatf("vec%0d.done", i), done, vecs[i].dn);
        end

        // Full play-through from PLAY at address 0: address saturates, then drain to DONE
        shifts = 0;
        for (int i = 0; i < CHART_LEN; i++) begin
            step(0, 0, 1);
            check($sformatf("play%0d.addr", i), chart_addr, (i + 1 < CHART_LEN) ? i + 1 : CHART_LEN - 1);
        end
        check("end.state_drain", state, 3);
        check("end.blank_drain", feed_blank, 1);
        check("end.judge_drain", judge_en, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        check("drain.state_mid", state, 3);
        step(0, 0, 1);
        check("drain.state_done", state, 5);
        check("drain.done", done, 1);
        check("drain.judge", judge_en, 0);
        check("drain.addr_hold", chart_addr, CHART_LEN - 1);
        step(0, 0, 1);
        step(0, 1, 0);
        check("done.sticky", state, 5);
        check("total_shifts", shifts, CHART_LEN + 3);

        // Pause in PLAY at address 5
        step(1, 0, 0);
        repeat (4) step(0, 0, 1);
        repeat (5) step(0, 0, 1);
        check("pause.pre_addr", chart_addr, 5);
        step(0, 1, 0);
`ifdef GAME_PAUSE_EN
        check("pause.state", state, 4);
        check("pause.judge", judge_en, 0);
        check("pause.blank", feed_blank, 0);
        shifts = 0;
        repeat (10) step(0, 0, 1);
        check("pause.addr_held", chart_addr, 5);
        check("pause.no_shift", shifts, 0);
        step(0, 1, 0);
        check("resume.state", state, 2);
        check("resume.judge", judge_en, 1);
`else
        check("nopause.state", state, 2);
        check("nopause.judge", judge_en, 1);
`endif
        step(0, 0, 1);
        check("after_pause.addr", chart_addr, 6);
        check("after_pause.shift", shift_pulse, 1);

        // Reset mid-PLAY at address 37
        step(1, 0, 0);
        repeat (4) step(0, 0, 1);
        repeat (37) step(0, 0, 1);
        check("pre_rst.addr", chart_addr, 37);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.state", state, 0);
        check("midrst.addr", chart_addr, 0);
        check("midrst.judge", judge_en, 0);
        check("midrst.blank", feed_blank, 1);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1);
        check("post_rst.idle", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level sequencer for a chart play-through. Owns the chart ROM address, paces the note queue shift and judgement enable from the beat tick, and runs the song lifecycle: idle, count-in, play, queue drain, done, plus optional pause. It sits between the clock divider/debouncers and the address/queue/judgement/accumulator datapath, replacing their ad-hoc shared reset with explicit clear and enable strobes.

## Interface
- COUNTDOWN_BEATS, 4: count-in beats before the first chart address is consumed (1..15).
- DRAIN_BEATS, 16: beats after the last chart address so the 16-deep queue empties (1..255).
- ADDR_W, 12: chart address width.
- CHART_LEN, 4096: number of chart entries (2..2^ADDR_W).
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- beat_tick  in  1  one-cycle pulse per chart step, synchronous to clk.
- start_pulse  in  1  one-cycle debounced start/restart request.
- pause_pulse  in  1  one-cycle debounced pause toggle.
- chart_addr  out  ADDR_W  ROM address of the next entry to load.
- shift_pulse  out  1  one-cycle queue shift strobe.
- feed_blank  out  1  high: queue loads NO_NOTE (2'b11) instead of ROM data.
- clear_pulse  out  1  one-cycle clear for queue, accumulator, judgement.
- judge_en  out  1  judgement and score accumulation allowed.
- countdown  out  4  count-in beats remaining; 0 outside COUNTDOWN.
- state  out  3  current state encoding.
- done  out  1  high in DONE.

## Operation
- States: IDLE=0, COUNTDOWN=1, PLAY=2, DRAIN=3, PAUSE=4, DONE=5; 6,7 unused, recover to IDLE next cycle.
- Event priority each cycle: start_pulse > pause_pulse > beat_tick.
- start_pulse in any state: go COUNTDOWN, countdown=COUNTDOWN_BEATS, chart_addr=0, clear_pulse=1 for one cycle; same-cycle beat_tick/pause_pulse discarded.
- COUNTDOWN: beat_tick decrements countdown; tick at countdown==1 -> PLAY, countdown=0. No shift_pulse, judge_en=0, feed_blank=1.
- PLAY: judge_en=1, feed_blank=0. beat_tick -> shift_pulse; chart_addr increments. Tick while chart_addr==CHART_LEN-1 -> DRAIN, drain counter=DRAIN_BEATS, chart_addr holds at CHART_LEN-1 (no wrap).
- DRAIN: judge_en=1, feed_blank=1. beat_tick -> shift_pulse, drain counter decrements; tick at counter==1 -> DONE.
- DONE: judge_en=0, done=1, no shift; only start_pulse leaves.
- PAUSE: entered by pause_pulse from PLAY or DRAIN; return state and counters saved. beat_tick ignored, judge_en=0, feed_blank unchanged. pause_pulse returns to saved state with counters intact. pause_pulse in IDLE/COUNTDOWN/DONE ignored.
- IDLE: all strobes 0; only start_pulse leaves.

## Timing
- All outputs registered; strobes and state/addr/counter changes appear one cycle after the qualifying input edge.
- shift_pulse and the chart_addr increment occur on the same edge; queue samples ROM at the pre-increment address on that pulse.
- clear_pulse coincides with entry to COUNTDOWN.
- Reset (any time, mid-song included): state=IDLE, chart_addr=0, countdown=0, drain counter=0, all strobes 0, judge_en=0, feed_blank=1, done=0.
- Back-to-back beat_tick each cycle legal; each yields one shift_pulse.

## Configuration
- GAME_PAUSE_EN defined: PAUSE state and pause_pulse behaviour as above.
- Not defined: pause_pulse ignored, PAUSE unreachable, no save registers; all else identical.

## Test plan
- Reset mid-PLAY at chart_addr=37 -> next cycle state=0, chart_addr=0, judge_en=0, feed_blank=1.
- start_pulse, then 4 beat_ticks (COUNTDOWN_BEATS=4) -> clear_pulse once, countdown 4,3,2,1,0, state=2 after 4th tick, zero shift_pulses.
- CHART_LEN=8, DRAIN_BEATS=3: 8 ticks in PLAY -> chart_addr 1..7 then holds 7, state=3; 3 more ticks -> state=5, done=1, total shift_pulse count 11.
- start_pulse and beat_tick same cycle in PLAY -> state=1, chart_addr=0, clear_pulse=1, no shift_pulse.
- GAME_PAUSE_EN: pause in PLAY at addr 5, 10 ticks, pause again -> addr stays 5 while paused, judge_en 0 then 1, next tick -> addr 6.
- Without GAME_PAUSE_EN: pause_pulse in PLAY -> state stays 2, next tick advances addr.
